// File: rtl/adc_sync_axil_slave.sv
// AXI4-Lite register slave with a delay/pulse sequencer that drives the ADC sync line.
// Holds CTRL/DELAY/WIDTH registers and a read-only STATUS word (sync count + busy).
module adc_sync_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            ext_trig,
  output logic                            sync_out,
  output logic                            busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } sync_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DELAY  = 2'd1;
  localparam logic [1:0] REG_WIDTH  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Byte-enable merge for the 16-bit RW registers.
  function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  strb);
    return {(strb[1] ? new_val[15:8] : old_val[15:8]),
            (strb[0] ? new_val[7:0]  : old_val[7:0])};
  endfunction

  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_sel_q, aw_sel_d;
  logic        w_held_q, w_held_d;
  logic [15:0] w_data_q, w_data_d;
  logic [1:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d, ext_en_q, ext_en_d;
  logic [15:0] delay_q, delay_d, width_q, width_d;
  logic [15:0] cnt_q, cnt_d, count_q, count_d;
  sync_state_e state_q, state_d;
  logic        sync_q, busy_q;
  logic        ext_d1_q, ext_d2_q;
  logic        commit, wr_ctrl, sw_trig, ext_rise, trig, ar_hs;
  logic        unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:16], S_AXI_WSTRB[3:2]};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign sync_out      = sync_q;
  assign busy          = busy_q;

  // Write channel: AW and W captured independently, committed once both are held.
  always_comb begin
    commit     = aw_held_q & w_held_q;
    aw_held_d  = aw_held_q;
    aw_sel_d   = aw_sel_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (S_AXI_AWVALID && awready_q) begin
        aw_held_d = 1'b1;
        aw_sel_d  = S_AXI_AWADDR[3:2];
      end else begin
        aw_held_d = aw_held_q;
      end
      if (S_AXI_WVALID && wready_q) begin
        w_held_d = 1'b1;
        w_data_d = S_AXI_WDATA[15:0];
        w_strb_d = S_AXI_WSTRB[1:0];
      end else begin
        w_held_d = w_held_q;
      end
    end
    if (commit) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Register file update and trigger qualification using post-write control bits.
  always_comb begin
    wr_ctrl  = commit && (aw_sel_q == REG_CTRL) && w_strb_q[0];
    en_d     = en_q;
    ext_en_d = ext_en_q;
    delay_d  = delay_q;
    width_d  = width_q;
    if (wr_ctrl) begin
      en_d     = w_data_q[0];
      ext_en_d = w_data_q[2];
    end else begin
      en_d     = en_q;
      ext_en_d = ext_en_q;
    end
    if (commit && (aw_sel_q == REG_DELAY)) begin
      delay_d = merge16(delay_q, w_data_q, w_strb_q);
    end else begin
      delay_d = delay_q;
    end
    if (commit && (aw_sel_q == REG_WIDTH)) begin
      width_d = merge16(width_q, w_data_q, w_strb_q);
    end else begin
      width_d = width_q;
    end
    sw_trig  = wr_ctrl & w_data_q[1] & en_d;
    ext_rise = ext_d1_q & ~ext_d2_q;
    trig     = sw_trig | (ext_rise & en_d & ext_en_d);
  end

  // Sync sequencer: IDLE -> DELAY (DELAY+1 cycles) -> PULSE (max(WIDTH,1) cycles).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (!en_d) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d = ST_DELAY;
            cnt_d   = delay_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_PULSE;
            cnt_d   = (width_q == 16'd0) ? 16'd1 : width_q;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_PULSE: begin
          if (cnt_q <= 16'd1) begin
            state_d = ST_IDLE;
            count_d = count_q + 16'd1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Read channel: RDATA is sampled at the AR handshake and held until RREADY.
  always_comb begin
    ar_hs    = S_AXI_ARVALID & arready_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (S_AXI_ARADDR[3:2])
        REG_CTRL:   rdata_d = {29'd0, ext_en_q, 1'b0, en_q};
        REG_DELAY:  rdata_d = {16'd0, delay_q};
        REG_WIDTH:  rdata_d = {16'd0, width_q};
        REG_STATUS: rdata_d = {15'd0, busy_q, count_q};
        default:    rdata_d = 32'd0;
      endcase
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = ~rvalid_d;
  end

  // AXI handshake state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      aw_sel_q  <= 2'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 16'd0;
      w_strb_q  <= 2'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_sel_q  <= aw_sel_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Control registers, trigger edge detector and sequencer state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q     <= 1'b0;
      ext_en_q <= 1'b0;
      delay_q  <= 16'd0;
      width_q  <= 16'd0;
      ext_d1_q <= 1'b0;
      ext_d2_q <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      count_q  <= 16'd0;
      sync_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      ext_en_q <= ext_en_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      ext_d1_q <= ext_trig;
      ext_d2_q <= ext_d1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      sync_q   <= (state_d == ST_PULSE);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

endmodule
